// File: rtl/mgmt_pwr_pkg.sv
// Shared types and defaults for the user-domain power sequencer.
// Holds the per-channel state encoding and default timing constants.
package mgmt_pwr_pkg;

    typedef enum logic [1:0] {
        PWR_OFF      = 2'd0,
        PWR_DEBOUNCE = 2'd1,
        PWR_POWERED  = 2'd2,
        PWR_ON       = 2'd3
    } pwr_state_e;

    localparam int PWR_DEBOUNCE_DEF = 16;
    localparam int PWR_SETTLE_DEF   = 8;
    localparam int PWR_CNT_W_DEF    = 8;

endpackage

// File: rtl/mgmt_pwr_seq_ch.sv
// One supply-domain channel: 2-flop synchronizer, counter and sequencing FSM.
// Ports: i_clk, i_rstn, i_vdd (async), i_sw_ena; o_pg, o_iena, o_fault (registered).
module mgmt_pwr_seq_ch
    import mgmt_pwr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PWR_DEBOUNCE_DEF,
    parameter int SETTLE_CYCLES   = PWR_SETTLE_DEF,
    parameter int CNT_W           = PWR_CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_vdd,
    input  logic i_sw_ena,
    output logic o_pg,
    output logic o_iena,
    output logic o_fault
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       r_sync;
    pwr_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pg;
    logic             r_iena;
    logic             r_fault;

    pwr_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_fault_nxt;
    logic             w_lvl;
    logic             w_q;

    assign w_lvl = r_sync[1];
    assign w_q   = w_lvl & i_sw_ena;

    // Saturating increment: the counter never wraps.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync  <= 2'b00;
            r_state <= PWR_OFF;
            r_cnt   <= '0;
            r_pg    <= 1'b0;
            r_iena  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_vdd};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pg    <= (w_state_nxt == PWR_POWERED) ||
                       (w_state_nxt == PWR_ON);
            r_iena  <= (w_state_nxt == PWR_ON);
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fault_nxt = 1'b0;
        unique case (r_state)
            PWR_OFF: begin
                if (w_q) begin
                    w_state_nxt = PWR_DEBOUNCE;
                    w_cnt_nxt   = '0;
                end
            end
            PWR_DEBOUNCE: begin
                if (!w_q) begin
                    w_state_nxt = PWR_OFF;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = PWR_POWERED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            PWR_POWERED: begin
                // Supply loss wins over a simultaneous software disable.
                if (!w_lvl) begin
                    w_state_nxt = PWR_OFF;
                    w_cnt_nxt   = '0;
                    w_fault_nxt = 1'b1;
                end else if (!i_sw_ena) begin
                    w_state_nxt = PWR_OFF;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == SET_LAST) begin
                    w_state_nxt = PWR_ON;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            PWR_ON: begin
                if (!w_lvl) begin
                    w_state_nxt = PWR_OFF;
                    w_cnt_nxt   = '0;
                    w_fault_nxt = 1'b1;
                end else if (!i_sw_ena) begin
                    w_state_nxt = PWR_OFF;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign o_pg    = r_pg;
    assign o_iena  = r_iena;
    assign o_fault = r_fault;

endmodule

// File: rtl/mgmt_pwr_sequencer.sv
// Power sequencer for the two user supply domains; two independent channels.
// Ports: caravel_clk/rstn, mprj*_vdd_logic1, sw_ena[1:0]; powergood, iena, pwr_fault[1:0].
module mgmt_pwr_sequencer
    import mgmt_pwr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PWR_DEBOUNCE_DEF,
    parameter int SETTLE_CYCLES   = PWR_SETTLE_DEF,
    parameter int CNT_W           = PWR_CNT_W_DEF
) (
    input  logic       caravel_clk,
    input  logic       caravel_rstn,
    input  logic       mprj_vdd_logic1,
    input  logic       mprj2_vdd_logic1,
    input  logic [1:0] sw_ena,
    output logic       user1_vcc_powergood,
    output logic       user2_vcc_powergood,
    output logic       user1_iena,
    output logic       user2_iena,
    output logic [1:0] pwr_fault
);

    logic w_fault1;
    logic w_fault2;

    mgmt_pwr_seq_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SETTLE_CYCLES   (SETTLE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch1 (
        .i_clk    (caravel_clk),
        .i_rstn   (caravel_rstn),
        .i_vdd    (mprj_vdd_logic1),
        .i_sw_ena (sw_ena[0]),
        .o_pg     (user1_vcc_powergood),
        .o_iena   (user1_iena),
        .o_fault  (w_fault1)
    );

    mgmt_pwr_seq_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SETTLE_CYCLES   (SETTLE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch2 (
        .i_clk    (caravel_clk),
        .i_rstn   (caravel_rstn),
        .i_vdd    (mprj2_vdd_logic1),
        .i_sw_ena (sw_ena[1]),
        .o_pg     (user2_vcc_powergood),
        .o_iena   (user2_iena),
        .o_fault  (w_fault2)
    );

    assign pwr_fault = {w_fault2, w_fault1};

endmodule

// File: tb/tb_mgmt_pwr_sequencer.sv
// Directed bench for mgmt_pwr_sequencer: vector table plus corner sequences.
// Ports exercised: all top-level inputs; all outputs compared.
module tb_mgmt_pwr_sequencer;

    logic       clk;
    logic       rstn;
    logic       vdd1;
    logic       vdd2;
    logic [1:0] sw;
    logic       pg1;
    logic       pg2;
    logic       ie1;
    logic       ie2;
    logic [1:0] flt;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       v1;
        logic       v2;
        logic [1:0] sw;
        int         n;
        logic [1:0] pg;
        logic [1:0] ie;
        logic [1:0] f;
        string      name;
    } vec_t;

    vec_t tbl[$];

    mgmt_pwr_sequencer dut (
        .caravel_clk         (clk),
        .caravel_rstn        (rstn),
        .mprj_vdd_logic1     (vdd1),
        .mprj2_vdd_logic1    (vdd2),
        .sw_ena              (sw),
        .user1_vcc_powergood (pg1),
        .user2_vcc_powergood (pg2),
        .user1_iena          (ie1),
        .user2_iena          (ie2),
        .pwr_fault           (flt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] epg,
                         input logic [1:0] eie, input logic [1:0] ef);
        logic [5:0] act;
        logic [5:0] exp;
        act = {pg2, pg1, ie2, ie1, flt};
        exp = {epg, eie, ef};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pg=%b ie=%b flt=%b, want pg=%b ie=%b flt=%b",
                     name, act[5:4], act[3:2], act[1:0], epg, eie, ef);
        end
    endtask

    task automatic add(input logic v1, input logic v2, input logic [1:0] s,
                       input int n, input logic [1:0] epg,
                       input logic [1:0] eie, input logic [1:0] ef,
                       input string name);
        vec_t v;
        v.v1 = v1; v.v2 = v2; v.sw = s; v.n = n;
        v.pg = epg; v.ie = eie; v.f = ef; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // pg/ie/f fields are {ch2, ch1}; edge counts are from reset release.
        add(1, 1, 2'b11, 18, 2'b00, 2'b00, 2'b00, "rise_e18");
        add(1, 1, 2'b11,  1, 2'b11, 2'b00, 2'b00, "rise_e19");
        add(1, 1, 2'b11,  7, 2'b11, 2'b00, 2'b00, "rise_e26");
        add(1, 1, 2'b11,  1, 2'b11, 2'b11, 2'b00, "rise_e27");
        add(0, 1, 2'b11,  2, 2'b11, 2'b11, 2'b00, "fall1_e2");
        add(0, 1, 2'b11,  1, 2'b10, 2'b10, 2'b01, "fall1_e3");
        add(0, 1, 2'b11,  1, 2'b10, 2'b10, 2'b00, "fault1_clr");
        add(1, 1, 2'b11, 18, 2'b10, 2'b10, 2'b00, "reup1_e18");
        add(1, 1, 2'b11,  1, 2'b11, 2'b10, 2'b00, "reup1_e19");
        add(1, 1, 2'b11,  8, 2'b11, 2'b11, 2'b00, "reup1_e27");
        add(1, 0, 2'b01,  1, 2'b01, 2'b01, 2'b00, "sw2_off_on");
        add(1, 0, 2'b01,  2, 2'b01, 2'b01, 2'b00, "ch2_flush");
        add(1, 1, 2'b11, 13, 2'b01, 2'b01, 2'b00, "ch2_deb10");
        add(1, 0, 2'b11,  2, 2'b01, 2'b01, 2'b00, "glitch_low");
        add(1, 1, 2'b11,  4, 2'b01, 2'b01, 2'b00, "glitch_old19");
        add(1, 1, 2'b11, 14, 2'b01, 2'b01, 2'b00, "glitch_new18");
        add(1, 1, 2'b11,  1, 2'b11, 2'b01, 2'b00, "glitch_new19");
        add(1, 1, 2'b11,  8, 2'b11, 2'b11, 2'b00, "glitch_new27");
        add(0, 0, 2'b11,  2, 2'b11, 2'b11, 2'b00, "both_fall_e2");
        add(0, 0, 2'b00,  1, 2'b00, 2'b00, 2'b11, "both_loss_sw");
        add(0, 0, 2'b00,  1, 2'b00, 2'b00, 2'b00, "both_fault_clr");

        rstn = 1'b0;
        vdd1 = 1'b1;
        vdd2 = 1'b1;
        sw   = 2'b11;
        step(3);
        check("reset_hold", 2'b00, 2'b00, 2'b00);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            vdd1 = tbl[i].v1;
            vdd2 = tbl[i].v2;
            sw   = tbl[i].sw;
            step(tbl[i].n);
            check(tbl[i].name, tbl[i].pg, tbl[i].ie, tbl[i].f);
        end

        // Software disable of channel 1 during settle, then restart.
        vdd1 = 1'b1;
        sw   = 2'b01;
        step(19);
        check("sw1_pwrd", 2'b01, 2'b00, 2'b00);
        step(2);
        check("sw1_settle", 2'b01, 2'b00, 2'b00);
        sw = 2'b00;
        step(1);
        check("sw1_clr", 2'b00, 2'b00, 2'b00);
        step(3);
        check("sw1_idle", 2'b00, 2'b00, 2'b00);
        sw = 2'b01;
        step(16);
        check("sw1_re16", 2'b00, 2'b00, 2'b00);
        step(1);
        check("sw1_re17", 2'b01, 2'b00, 2'b00);
        step(3);
        check("sw1_settle2", 2'b01, 2'b00, 2'b00);

        // Asynchronous reset in the middle of settle.
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async", 2'b00, 2'b00, 2'b00);
        step(2);
        check("rst_held", 2'b00, 2'b00, 2'b00);
        rstn = 1'b1;
        step(18);
        check("rst_re18", 2'b00, 2'b00, 2'b00);
        step(1);
        check("rst_re19", 2'b01, 2'b00, 2'b00);
        step(7);
        check("rst_re26", 2'b01, 2'b00, 2'b00);
        step(1);
        check("rst_re27", 2'b01, 2'b01, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
